// File: rtl/toom8_pkg.sv
// toom8_pkg: shared Toom-8 multiplier widths and the recompose stage state type.
package toom8_pkg;
    localparam int LIMB_W    = 128;
    localparam int NUM_LIMBS = 8;
    localparam int NUM_COEF  = 2 * NUM_LIMBS - 1;
    localparam int COEF_W    = 2 * LIMB_W + 4;
    localparam int PROD_W    = LIMB_W * (NUM_COEF + 1);
    localparam int SUM_W     = COEF_W + 1;

    typedef enum logic {ACCUM, DONE} rec_state_e;
endpackage

// File: rtl/toom8_recompose.sv
// toom8_recompose: serial carry-propagating overlap-add of the 15 Toom-8 product coefficients.
module toom8_recompose
    import toom8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              overflow
);
    rec_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [SUM_W-1:0]  acc_q, acc_d, sum;
    logic [PROD_W-1:0] product_q, product_d;
    logic              overflow_q, overflow_d, out_valid_q, out_valid_d;
    logic              hs, last;

    assign in_ready  = state_q == ACCUM;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign overflow  = overflow_q;

    always_comb begin
        hs          = in_valid && in_ready;
        last        = cnt_q == 4'(NUM_COEF - 1);
        sum         = (acc_q >> LIMB_W) + SUM_W'(coef);
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        product_d   = product_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        if (hs) begin
            product_d[LIMB_W*int'(cnt_q) +: LIMB_W] = sum[LIMB_W-1:0];
            acc_d = sum;
            cnt_d = cnt_q + 4'd1;
            // The final carry spills into the top limb; anything above it is overflow.
            if (last) begin
                product_d[PROD_W-1 -: LIMB_W] = sum[2*LIMB_W-1:LIMB_W];
                overflow_d  = |sum[COEF_W:2*LIMB_W];
                state_d     = DONE;
                out_valid_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            state_d     = ACCUM;
            cnt_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_toom8_recompose.sv
// tb_toom8_recompose: random and directed coefficient streams checked against a wide-integer sum model.
module tb_toom8_recompose;
    import toom8_pkg::*;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, out_valid, out_ready, overflow;
    logic [COEF_W-1:0] coef;
    logic [PROD_W-1:0] product;
    logic [COEF_W-1:0] c [NUM_COEF];
    logic [1023:0]     a_op;
    logic [2047:0]     a_sq;
    int                errs = 0, checks = 0;

    toom8_recompose dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .coef(coef),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2303:0] model();
        logic [2303:0] s = '0;
        for (int k = 0; k < NUM_COEF; k++) s += 2304'(c[k]) << (LIMB_W * k);
        return s;
    endfunction

    task automatic send(input int n, input int max_gap);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            int gap = $urandom_range(max_gap, 0);
            repeat (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            coef = c[k];
            if (k == NUM_COEF - 1) check("pre_valid", 256'(out_valid), 256'(0));
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t == 20) check("hs_timeout", 256'(0), 256'(1));
            @(posedge clk);
            #1;
        end
        if (n == NUM_COEF) begin
            check("latency_valid", 256'(out_valid), 256'(1));
            check("done_in_ready", 256'(in_ready), 256'(0));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_prod(input string name, input logic [2303:0] exp);
        for (int i = 0; i < NUM_COEF + 1; i++)
            check($sformatf("%s_limb%0d", name, i), 256'(product[LIMB_W*i +: LIMB_W]),
                  256'(exp[LIMB_W*i +: LIMB_W]));
        check({name, "_ovf"}, 256'(overflow), 256'(|exp[2303:PROD_W]));
    endtask

    task automatic finish(input string name, input int hold);
        logic [2303:0] exp = model();
        check_prod(name, exp);
        if (hold > 0) begin
            in_valid = 1'b1;
            coef = COEF_W'({$urandom, $urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom});
            repeat (hold) begin
                @(negedge clk);
                check({name, "_bp_ready"}, 256'(in_ready), 256'(0));
                check({name, "_bp_valid"}, 256'(out_valid), 256'(1));
            end
            check_prod({name, "_bp"}, exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_acc_valid"}, 256'(out_valid), 256'(0));
        check({name, "_acc_ready"}, 256'(in_ready), 256'(1));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic load_square();
        logic [127:0] a [NUM_LIMBS];
        for (int i = 0; i < NUM_LIMBS; i++) a[i] = (i == 0) ? 128'd253 : 128'(i + 1);
        a_op = '0;
        for (int i = 0; i < NUM_LIMBS; i++) a_op[LIMB_W*i +: LIMB_W] = a[i];
        a_sq = 2048'(a_op) * 2048'(a_op);
        for (int k = 0; k < NUM_COEF; k++) c[k] = '0;
        for (int i = 0; i < NUM_LIMBS; i++)
            for (int j = 0; j < NUM_LIMBS; j++) c[i+j] += COEF_W'(a[i] * a[j]);
    endtask

    task automatic check_square(input string name);
        for (int i = 0; i < NUM_COEF + 1; i++)
            check($sformatf("%s_ab%0d", name, i), 256'(product[LIMB_W*i +: LIMB_W]),
                  256'(a_sq[LIMB_W*i +: LIMB_W]));
        check({name, "_l0"}, 256'(product[127:0]), 256'(64009));
        check({name, "_l14"}, 256'(product[LIMB_W*14 +: LIMB_W]), 256'(64));
        check({name, "_l15"}, 256'(product[LIMB_W*15 +: LIMB_W]), 256'(0));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        coef = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", 256'(out_valid), 256'(0));
        check("rst_ready", 256'(in_ready), 256'(1));
        check("rst_ovf", 256'(overflow), 256'(0));
        check("rst_prod", 256'(|product), 256'(0));

        load_square();
        send(NUM_COEF, 0);
        check_square("sq");
        finish("sq", 10);

        for (int k = 0; k < NUM_COEF; k++) c[k] = '0;
        c[0] = (COEF_W'(1) << 128) + COEF_W'(5);
        c[1] = (COEF_W'(1) << 128) - COEF_W'(1);
        send(NUM_COEF, 0);
        check("carry_l0", 256'(product[127:0]), 256'(5));
        check("carry_l2", 256'(product[383:256]), 256'(1));
        finish("carry", 0);

        for (int k = 0; k < NUM_COEF; k++) c[k] = '0;
        c[14] = COEF_W'(1) << 256;
        send(NUM_COEF, 1);
        check("ovf1_flag", 256'(overflow), 256'(1));
        finish("ovf1", 0);
        c[14] = (COEF_W'(1) << 256) - COEF_W'(1);
        send(NUM_COEF, 1);
        check("ovf0_flag", 256'(overflow), 256'(0));
        check("ovf0_l15", 256'(product[PROD_W-1 -: LIMB_W]), 256'({128{1'b1}}));
        finish("ovf0", 3);

        load_square();
        send(7, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", 256'(out_valid), 256'(0));
        check("mid_rst_ready", 256'(in_ready), 256'(1));
        check("mid_rst_prod", 256'(|product), 256'(0));
        send(NUM_COEF, 0);
        check_square("post_rst");
        finish("post_rst", 0);

        load_square();
        send(NUM_COEF, 5);
        check_square("stall");
        finish("stall", 0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NUM_COEF; k++)
                c[k] = COEF_W'({$urandom, $urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom}) >> $urandom_range(259, 0);
            send(NUM_COEF, 3);
            finish($sformatf("rnd%0d", r), $urandom_range(4, 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
